decode_stage: RTL and testbench

Registered, handshaked MIPS instruction-decode stage with a load-use hazard scoreboard. It sits between the fetch stage and the execute stage. It turns a 32-bit instruction into the datapath control bundle plus register addresses and an extended immediate. Branch resolution moves to execute, so decode carries no combinational dependence on the ALU zero flag.

---
 rtl/decode_stage.sv | 188 ++++++++++++++++++
 tb/tb_decode_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered MIPS decode stage with valid/ready handshake and load-use scoreboard
module decode_stage #(
  parameter int PC_WIDTH = 32,
  parameter int NUM_REGS = 32,
  parameter int LOGIC_IMM_ZEXT = 1,
  parameter int JAL_LINK_REG = 31,
  localparam int REG_AW = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  input  logic                wb_clr_valid,
  input  logic [REG_AW-1:0]   wb_clr_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [REG_AW-1:0]   out_rs,
  output logic [REG_AW-1:0]   out_rt,
  output logic [REG_AW-1:0]   out_rd,
  output logic [31:0]         out_imm,
  output logic [4:0]          out_shamt,
  output logic                out_data_mem_wren,
  output logic                out_reg_file_wren,
  output logic                out_reg_file_dmux_sel,
  output logic                out_reg_file_rmux_sel,
  output logic                out_alu_mux_sel,
  output logic [3:0]          out_alu_op,
  output logic [2:0]          out_pc_control,
  output logic                out_illegal
);
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
    logic [REG_AW-1:0]   rd;
    logic [31:0]         imm;
    logic [4:0]          shamt;
    logic                dmw;
    logic                rfw;
    logic                dmux;
    logic                rmux;
    logic                amux;
    logic [3:0]          alu;
    logic [2:0]          pcc;
    logic                ill;
    logic                load;
  } bundle_t;

  logic [5:0] op, fn;
  logic r_type, is_j, is_jal, is_jr, is_jalr, is_beq, is_bne, is_load, is_store;
  logic r_ok, i_ok, i_wr, ill, rs_busy, rt_busy, hazard, in_fire, out_fire;
  logic [3:0] r_alu, i_alu;
  logic [REG_AW-1:0] src_s, src_t, dest;
  logic out_valid_q, out_valid_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  bundle_t dec, bundle_q, bundle_d;

  assign op = in_instr[31:26];
  assign fn = in_instr[5:0];
  assign src_s = in_instr[21 +: REG_AW];
  assign src_t = in_instr[16 +: REG_AW];
  assign r_type = op == 6'h00;
  assign is_j = op == 6'h02;
  assign is_jal = op == 6'h03;
  assign is_beq = op == 6'h04;
  assign is_bne = op == 6'h05;
  assign is_jr = r_type && fn == 6'h08;
  assign is_jalr = r_type && fn == 6'h09;
  assign is_load = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign is_store = op inside {6'h28, 6'h29, 6'h2b};
  assign ill = r_type ? !r_ok : !i_ok;
  assign dest = r_type ? in_instr[11 +: REG_AW] : is_jal ? REG_AW'(JAL_LINK_REG) : src_t;

  // R-type funct to ALU op
  always_comb begin
    r_alu = 4'hf;
    r_ok = 1'b1;
    case (fn)
      6'h00: r_alu = 4'h8;
      6'h02: r_alu = 4'h9;
      6'h03: r_alu = 4'ha;
      6'h08, 6'h09: r_alu = 4'hf;
      6'h20: r_alu = 4'hb;
      6'h21: r_alu = 4'h2;
      6'h22: r_alu = 4'he;
      6'h23: r_alu = 4'h6;
      6'h24: r_alu = 4'h0;
      6'h25: r_alu = 4'h1;
      6'h26: r_alu = 4'h3;
      6'h27: r_alu = 4'h4;
      6'h2a: r_alu = 4'h7;
      default: r_ok = 1'b0;
    endcase
  end

  // I/J-type opcode to ALU op and rt-writeback flag
  always_comb begin
    i_alu = 4'hf;
    i_ok = 1'b1;
    i_wr = 1'b1;
    case (op)
      6'h02, 6'h03: i_wr = 1'b0;
      6'h04, 6'h05: begin i_alu = 4'he; i_wr = 1'b0; end
      6'h08: i_alu = 4'hb;
      6'h09: i_alu = 4'h2;
      6'h0a: i_alu = 4'h7;
      6'h0c: i_alu = 4'h0;
      6'h0d: i_alu = 4'h1;
      6'h0e: i_alu = 4'h3;
      6'h0f: i_alu = 4'hc;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: i_alu = 4'hb;
      6'h28, 6'h29, 6'h2b: begin i_alu = 4'hb; i_wr = 1'b0; end
      default: begin i_ok = 1'b0; i_wr = 1'b0; end
    endcase
  end

  // assemble the control bundle for the offered instruction
  always_comb begin
    dec = '0;
    dec.pc = in_pc;
    dec.rs = src_s;
    dec.rt = src_t;
    dec.rd = dest;
    dec.imm = (is_j || is_jal) ? {6'h0, in_instr[25:0]} :
              (op == 6'h0f) ? {in_instr[15:0], 16'h0} :
              (LOGIC_IMM_ZEXT != 0 && (op == 6'h0c || op == 6'h0d)) ? {16'h0, in_instr[15:0]} :
              {{16{in_instr[15]}}, in_instr[15:0]};
    dec.shamt = in_instr[10:6];
    dec.dmw = is_store;
    dec.rfw = (r_type ? !is_jr : (is_jal || i_wr)) && !ill && dest != '0;
    dec.dmux = !is_load;
    dec.rmux = r_type;
    dec.amux = r_type || is_beq || is_bne;
    dec.alu = ill ? 4'hf : r_type ? r_alu : i_alu;
    dec.pcc = (is_j || is_jal) ? 3'd1 : (is_jr || is_jalr) ? 3'd2 : is_beq ? 3'd3 : is_bne ? 3'd4 : 3'd0;
    dec.ill = ill;
    dec.load = is_load;
  end

  assign rs_busy = src_s != '0 && (sb_q[src_s] || (out_valid_q && bundle_q.load && bundle_q.rd == src_s));
  assign rt_busy = src_t != '0 && (sb_q[src_t] || (out_valid_q && bundle_q.load && bundle_q.rd == src_t));
  assign hazard = in_valid && ((!(is_j || is_jal) && rs_busy) || ((r_type || is_beq || is_bne || is_store) && rt_busy));
  assign in_ready = !rst && (!out_valid_q || out_ready) && !hazard && !flush;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // next-state for valid, bundle and scoreboard; a killed load never marks its destination busy
  always_comb begin
    out_valid_d = flush ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : out_valid_q;
    bundle_d = in_fire ? dec : bundle_q;
    sb_d = sb_q;
    if (wb_clr_valid && wb_clr_addr != '0) sb_d[wb_clr_addr] = 1'b0;
    if (out_fire && !flush && bundle_q.load && bundle_q.rd != '0) sb_d[bundle_q.rd] = 1'b1;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q <= '0;
      sb_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q <= bundle_d;
      sb_q <= sb_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc = bundle_q.pc;
  assign out_rs = bundle_q.rs;
  assign out_rt = bundle_q.rt;
  assign out_rd = bundle_q.rd;
  assign out_imm = bundle_q.imm;
  assign out_shamt = bundle_q.shamt;
  assign out_data_mem_wren = bundle_q.dmw;
  assign out_reg_file_wren = bundle_q.rfw;
  assign out_reg_file_dmux_sel = bundle_q.dmux;
  assign out_reg_file_rmux_sel = bundle_q.rmux;
  assign out_alu_mux_sel = bundle_q.amux;
  assign out_alu_op = bundle_q.alu;
  assign out_pc_control = bundle_q.pcc;
  assign out_illegal = bundle_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized scoreboard bench for decode_stage against an instruction-level model
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst, in_valid, flush, wb_clr_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0] wb_clr_addr;
  logic in_ready, out_valid, dmw, rfw, dmux, rmux, amux, ill;
  logic [31:0] out_pc, out_imm;
  logic [4:0] out_rs, out_rt, out_rd, out_shamt;
  logic [3:0] alu;
  logic [2:0] pcc;
  logic z_in_ready, z_out_valid, z_dmw, z_rfw, z_dmux, z_rmux, z_amux, z_ill;
  logic [31:0] z_out_pc, z_out_imm;
  logic [4:0] z_out_rs, z_out_rt, z_out_rd, z_out_shamt;
  logic [3:0] z_alu;
  logic [2:0] z_pcc;

  always #5 clk = ~clk;

  decode_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .wb_clr_valid(wb_clr_valid), .wb_clr_addr(wb_clr_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm(out_imm), .out_shamt(out_shamt), .out_data_mem_wren(dmw), .out_reg_file_wren(rfw),
    .out_reg_file_dmux_sel(dmux), .out_reg_file_rmux_sel(rmux), .out_alu_mux_sel(amux),
    .out_alu_op(alu), .out_pc_control(pcc), .out_illegal(ill)
  );

  decode_stage #(.LOGIC_IMM_ZEXT(0)) u_sext (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .wb_clr_valid(wb_clr_valid), .wb_clr_addr(wb_clr_addr), .out_valid(z_out_valid),
    .out_ready(out_ready), .out_pc(z_out_pc), .out_rs(z_out_rs), .out_rt(z_out_rt), .out_rd(z_out_rd),
    .out_imm(z_out_imm), .out_shamt(z_out_shamt), .out_data_mem_wren(z_dmw), .out_reg_file_wren(z_rfw),
    .out_reg_file_dmux_sel(z_dmux), .out_reg_file_rmux_sel(z_rmux), .out_alu_mux_sel(z_amux),
    .out_alu_op(z_alu), .out_pc_control(z_pcc), .out_illegal(z_ill)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0] rs, rt, rd;
    logic [31:0] imm, imm_s;
    logic [4:0] shamt;
    logic dmw, rfw, dmux, rmux, amux;
    logic [3:0] alu;
    logic [2:0] pcc;
    logic ill, load, rd_rs, rd_rt;
  } exp_t;

  localparam logic [5:0] R_FNS [16] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                                       6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h01, 6'h3f};
  localparam logic [5:0] I_OPS [24] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0c,
                                       6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                                       6'h28, 6'h29, 6'h2b, 6'h01, 6'h3f, 6'h22, 6'h06, 6'h10};

  exp_t q[$];
  exp_t held;
  bit held_v, leave, started, last_acc;
  bit sb [32];
  logic [31:0] pc_ctr = 32'h0040_0000;
  int vectors, miscompares;

  task automatic check(string name, logic [95:0] act, logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // instruction-level reference: what each MIPS instruction means for the datapath
  function automatic exp_t model(logic [31:0] i, logic [31:0] pc);
    exp_t e;
    logic [31:0] sx, zx;
    bit wr;
    sx = {{16{i[15]}}, i[15:0]};
    zx = {16'h0, i[15:0]};
    wr = 0;
    e = '0;
    e.pc = pc; e.rs = i[25:21]; e.rt = i[20:16]; e.rd = i[20:16]; e.shamt = i[10:6];
    e.imm = sx; e.dmux = 1; e.alu = 4'hf; e.rd_rs = 1;
    case (i[31:26])
      6'h00: begin
        e.rd = i[15:11]; e.rmux = 1; e.amux = 1; e.rd_rt = 1; wr = 1;
        case (i[5:0])
          6'h00: e.alu = 4'h8;
          6'h02: e.alu = 4'h9;
          6'h03: e.alu = 4'ha;
          6'h08: begin e.pcc = 2; wr = 0; end
          6'h09: e.pcc = 2;
          6'h20: e.alu = 4'hb;
          6'h21: e.alu = 4'h2;
          6'h22: e.alu = 4'he;
          6'h23: e.alu = 4'h6;
          6'h24: e.alu = 4'h0;
          6'h25: e.alu = 4'h1;
          6'h26: e.alu = 4'h3;
          6'h27: e.alu = 4'h4;
          6'h2a: e.alu = 4'h7;
          default: e.ill = 1;
        endcase
      end
      6'h02: begin e.pcc = 1; e.rd_rs = 0; e.imm = {6'h0, i[25:0]}; end
      6'h03: begin e.pcc = 1; e.rd_rs = 0; e.imm = {6'h0, i[25:0]}; e.rd = 31; wr = 1; end
      6'h04: begin e.pcc = 3; e.alu = 4'he; e.amux = 1; e.rd_rt = 1; end
      6'h05: begin e.pcc = 4; e.alu = 4'he; e.amux = 1; e.rd_rt = 1; end
      6'h08: begin e.alu = 4'hb; wr = 1; end
      6'h09: begin e.alu = 4'h2; wr = 1; end
      6'h0a: begin e.alu = 4'h7; wr = 1; end
      6'h0c: begin e.alu = 4'h0; wr = 1; e.imm = zx; end
      6'h0d: begin e.alu = 4'h1; wr = 1; e.imm = zx; end
      6'h0e: begin e.alu = 4'h3; wr = 1; end
      6'h0f: begin e.alu = 4'hc; wr = 1; e.imm = {i[15:0], 16'h0}; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin e.alu = 4'hb; wr = 1; e.load = 1; e.dmux = 0; end
      6'h28, 6'h29, 6'h2b: begin e.alu = 4'hb; e.dmw = 1; e.rd_rt = 1; end
      default: e.ill = 1;
    endcase
    e.imm_s = (i[31:26] == 6'h0c || i[31:26] == 6'h0d) ? sx : e.imm;
    e.rfw = wr && !e.ill && e.rd != 0;
    return e;
  endfunction

  function automatic bit busy(logic [4:0] r);
    return r != 0 && (sb[r] || (held_v && held.load && held.rd == r));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) begin
      w[31:26] = (k < 3) ? 6'h00 : I_OPS[$urandom_range(0, 23)];
      if (k < 3) w[5:0] = R_FNS[$urandom_range(0, 15)];
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      w[15:11] = 5'($urandom_range(0, 7));
    end
    return w;
  endfunction

  // monitor: compare whatever the DUT presents with the oldest expected bundle, retire it on transfer or flush
  always @(negedge clk) begin
    if (started) begin
      held_v = q.size() != 0;
      leave = 0;
      check("out_valid", out_valid, held_v);
      check("z_out_valid", z_out_valid, held_v);
      if (held_v) begin
        held = q[0];
        check("pc", out_pc, held.pc);
        check("regs", {out_rs, out_rt, out_rd, out_shamt}, {held.rs, held.rt, held.rd, held.shamt});
        check("imm", out_imm, held.imm);
        check("ctrl", {dmw, rfw, dmux, rmux, amux, alu, pcc, ill},
              {held.dmw, held.rfw, held.dmux, held.rmux, held.amux, held.alu, held.pcc, held.ill});
        check("z_imm", z_out_imm, held.imm_s);
        check("z_rest", {z_out_pc, z_out_rs, z_out_rt, z_out_rd, z_out_shamt, z_dmw, z_rfw, z_dmux, z_rmux, z_amux, z_alu, z_pcc, z_ill},
              {held.pc, held.rs, held.rt, held.rd, held.shamt, held.dmw, held.rfw, held.dmux, held.rmux, held.amux, held.alu, held.pcc, held.ill});
      end
      if (rst) q.delete();
      else if (held_v && (flush || out_ready)) begin
        leave = !flush;
        void'(q.pop_front());
      end
    end
  end

  // one clock of stimulus; predicts acceptance and keeps the model scoreboard
  task automatic cycle(bit r, bit v, logic [31:0] ins, bit ordy, bit fl, bit wv, logic [4:0] wa);
    exp_t e;
    bit haz, er;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_instr = ins; in_pc = pc_ctr; out_ready = ordy;
    flush = fl; wb_clr_valid = wv; wb_clr_addr = wa;
    @(negedge clk);
    #1;
    e = model(ins, pc_ctr);
    haz = v && ((e.rd_rs && busy(e.rs)) || (e.rd_rt && busy(e.rt)));
    er = !r && (!held_v || ordy) && !haz && !fl;
    if (started) begin
      check("in_ready", in_ready, er);
      check("z_in_ready", z_in_ready, er);
    end
    last_acc = v && er;
    if (last_acc) begin
      q.push_back(e);
      pc_ctr += 4;
    end
    if (r) sb = '{default: 0};
    else begin
      if (wv && wa != 0) sb[wa] = 0;
      if (leave && held.load && held.rd != 0) sb[held.rd] = 1;
    end
  endtask

  task automatic offer(logic [31:0] ins, bit wv = 0, logic [4:0] wa = 0);
    cycle(0, 1, ins, 1, 0, wv, wa);
  endtask

  task automatic idle(bit ordy);
    cycle(0, 0, 32'h0, ordy, 0, 0, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    flush = 0; wb_clr_valid = 0; wb_clr_addr = 0;
    cycle(1, 0, 0, 0, 0, 0, 0);
    started = 1;
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("reset_pc_imm", {out_pc, out_imm}, 0);
    check("reset_ctrl", {out_rs, out_rt, out_rd, out_shamt, dmw, rfw, dmux, rmux, amux, alu, pcc, ill}, 0);
    offer(32'h0022_1821);
    idle(1);
    check("addu_fields", {out_rs, out_rt, out_rd, alu, rfw, rmux, amux, pcc}, {5'd1, 5'd2, 5'd3, 4'b0010, 1'b1, 1'b1, 1'b1, 3'b000});
    offer(32'h8C22_0000);
    for (int n = 0; n < 3; n++) offer(32'h0042_2020);
    check("load_use_stall", in_ready, 0);
    offer(32'h0042_2020, 1, 2);
    for (int n = 0; n < 4 && !last_acc; n++) offer(32'h0042_2020);
    idle(1);
    check("add_after_clear", {out_valid, alu, out_rd}, {1'b1, 4'b1011, 5'd4});
    offer(32'h1022_0004);
    idle(1);
    check("beq_fields", {pcc, alu, rfw, out_imm}, {3'b011, 4'b1110, 1'b0, 32'h4});
    offer(32'h3C01_FFFF);
    idle(1);
    check("lui_fields", {out_imm, alu}, {32'hFFFF_0000, 4'b1100});
    offer(32'h0800_0100);
    for (int n = 0; n < 3; n++) idle(0);
    check("j_held", {out_valid, pcc, out_imm, in_ready}, {1'b1, 3'b001, 32'h100, 1'b0});
    cycle(0, 1, 32'h0022_1821, 0, 1, 0, 0);
    idle(1);
    check("flush_valid", out_valid, 0);
    offer(32'hFC00_0000);
    idle(1);
    check("illegal", {ill, alu, dmw, rfw}, {1'b1, 4'b1111, 1'b0, 1'b0});
    offer(32'h3020_FFFF);
    idle(1);
    check("andi_zext", out_imm, 32'h0000_FFFF);
    check("andi_sext", z_out_imm, 32'hFFFF_FFFF);
    offer(32'h8C05_0000);
    cycle(0, 0, 0, 1, 0, 1, 5);
    offer(32'h00A0_0021);
    check("set_wins", in_ready, 0);
    offer(32'h00A0_0021, 1, 5);
    for (int n = 0; n < 4 && !last_acc; n++) offer(32'h00A0_0021);
    offer(32'h8C26_0000);
    idle(0);
    idle(0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("reset_midstall", out_valid, 0);
    offer(32'h00C0_0021);
    idle(1);
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
